// File: rtl/sprite_layer_if.sv
// ============================================================================
// Module      : sprite_layer_if
// Description : Pixel, control and colour signals of the sprite layer.
//               SPRITE_FLIP_EN adds the flip_h control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sprite_layer_if;
    logic [9:0]  h_pos;
    logic [9:0]  v_pos;
    logic        video_enable;
    logic        frame_tick;
    logic        pos_we;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        bmp_we;
    logic [3:0]  bmp_row;
    logic [15:0] bmp_data;
    logic [11:0] sprite_color;
    logic [11:0] bg_color;
    logic [11:0] color_data;
    logic        pos_pending;
`ifdef SPRITE_FLIP_EN
    logic        flip_h;
`endif

    modport master (
`ifdef SPRITE_FLIP_EN
        output flip_h,
`endif
        output h_pos, v_pos, video_enable, frame_tick,
        output pos_we, pos_x, pos_y,
        output bmp_we, bmp_row, bmp_data,
        output sprite_color, bg_color,
        input  color_data, pos_pending
    );

    modport slave (
`ifdef SPRITE_FLIP_EN
        input  flip_h,
`endif
        input  h_pos, v_pos, video_enable, frame_tick,
        input  pos_we, pos_x, pos_y,
        input  bmp_we, bmp_row, bmp_data,
        input  sprite_color, bg_color,
        output color_data, pos_pending
    );
endinterface

`default_nettype wire

// File: rtl/sprite_layer.sv
// ============================================================================
// Module      : sprite_layer
// Description : 16x16 1-bpp sprite over a background colour, two-stage
//               pixel pipeline, frame-committed position. Optional
//               horizontal mirroring when SPRITE_FLIP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_layer #(
    parameter int H_MAX = 640,
    parameter int V_MAX = 480
) (
    input  wire logic     pixel_clk,
    input  wire logic     reset,
    sprite_layer_if.slave bus
);

    localparam logic [10:0] c_h_max  = 11'(H_MAX);
    localparam logic [10:0] c_v_max  = 11'(V_MAX);
    localparam logic [10:0] c_size   = 11'd16;

    // Position double buffer
    logic [9:0]  r_pend_x;
    logic [9:0]  r_pend_y;
    logic [9:0]  r_act_x;
    logic [9:0]  r_act_y;
    logic        r_pend_valid;
`ifdef SPRITE_FLIP_EN
    logic        r_pend_flip;
    logic        r_act_flip;
`endif

    logic [15:0] r_bitmap [0:15];

    // Pipeline registers
    logic        r_hit1;
    logic [3:0]  r_col1;
    logic [15:0] r_row1;
    logic        r_ven1;
    logic [11:0] r_color;

    // Stage-1 combinational terms
    logic [10:0] w_h;
    logic [10:0] w_v;
    logic [10:0] w_ax;
    logic [10:0] w_ay;
    logic [10:0] w_x_end;
    logic [10:0] w_y_end;
    logic        w_hit;
    logic [3:0]  w_dx;
    logic [3:0]  w_dy;
    logic [3:0]  w_bit_idx;
    logic        w_bit;

    // Commit first, then a same-cycle write overrides pending and re-arms valid.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            r_pend_x     <= '0;
            r_pend_y     <= '0;
            r_act_x      <= '0;
            r_act_y      <= '0;
            r_pend_valid <= 1'b0;
`ifdef SPRITE_FLIP_EN
            r_pend_flip  <= 1'b0;
            r_act_flip   <= 1'b0;
`endif
        end else begin
            if (bus.frame_tick && r_pend_valid) begin
                r_act_x      <= r_pend_x;
                r_act_y      <= r_pend_y;
`ifdef SPRITE_FLIP_EN
                r_act_flip   <= r_pend_flip;
`endif
                r_pend_valid <= 1'b0;
            end
            if (bus.pos_we) begin
                r_pend_x     <= bus.pos_x;
                r_pend_y     <= bus.pos_y;
`ifdef SPRITE_FLIP_EN
                r_pend_flip  <= bus.flip_h;
`endif
                r_pend_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                r_bitmap[i] <= '0;
            end
        end else if (bus.bmp_we) begin
            r_bitmap[bus.bmp_row] <= bus.bmp_data;
        end
    end

    // 11-bit bounds so a sprite near column 1023 clips instead of wrapping.
    assign w_h     = {1'b0, bus.h_pos};
    assign w_v     = {1'b0, bus.v_pos};
    assign w_ax    = {1'b0, r_act_x};
    assign w_ay    = {1'b0, r_act_y};
    assign w_x_end = w_ax + c_size;
    assign w_y_end = w_ay + c_size;
    assign w_hit   = (w_h >= w_ax) && (w_h < w_x_end) &&
                     (w_v >= w_ay) && (w_v < w_y_end) &&
                     (w_h < c_h_max) && (w_v < c_v_max);
    assign w_dx    = bus.h_pos[3:0] - r_act_x[3:0];
    assign w_dy    = bus.v_pos[3:0] - r_act_y[3:0];

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            r_hit1 <= 1'b0;
            r_col1 <= '0;
            r_row1 <= '0;
            r_ven1 <= 1'b0;
        end else begin
            r_hit1 <= w_hit;
            r_col1 <= w_dx;
            r_row1 <= r_bitmap[w_dy];
            r_ven1 <= bus.video_enable;
        end
    end

    // Bit 15 is the leftmost pixel; mirroring indexes the row directly.
`ifdef SPRITE_FLIP_EN
    assign w_bit_idx = r_act_flip ? r_col1 : ~r_col1;
`else
    assign w_bit_idx = ~r_col1;
`endif
    assign w_bit = r_row1[w_bit_idx];

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            r_color <= '0;
        end else if (!r_ven1) begin
            r_color <= '0;
        end else if (r_hit1 && w_bit) begin
            r_color <= bus.sprite_color;
        end else begin
            r_color <= bus.bg_color;
        end
    end

    assign bus.color_data  = r_color;
    assign bus.pos_pending = r_pend_valid;

endmodule

`default_nettype wire

// File: tb/tb_sprite_layer.sv
// ============================================================================
// Module      : tb_sprite_layer
// Description : Directed bench for sprite_layer with a pixel-level model
//               checked every cycle plus hand-computed pixel expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_layer;

    localparam int c_h_max = 640;
    localparam int c_v_max = 480;

    logic pixel_clk = 1'b0;
    logic reset     = 1'b1;
    int   checks    = 0;
    int   errors    = 0;
    bit   chk_en    = 1'b0;

    sprite_layer_if bus ();

    sprite_layer #(
        .H_MAX (c_h_max),
        .V_MAX (c_v_max)
    ) dut (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .bus       (bus.slave)
    );

    always #5 pixel_clk = ~pixel_clk;

    // ---------------- behavioural model ----------------
    int          m_ax, m_ay, m_px, m_py;
    bit          m_pv;
    bit          m_af, m_pf;
    logic [15:0] m_bmp [16];
    bit          m_ve_d, m_spr_d;
    logic [11:0] m_color;

    function automatic bit sprite_px(int h, int v);
        int c, r;
        if (!(h >= m_ax && h < m_ax + 16 && v >= m_ay && v < m_ay + 16 &&
              h < c_h_max && v < c_v_max))
            return 1'b0;
        c = h - m_ax;
        r = v - m_ay;
        if (m_af) return m_bmp[r][c];
        return m_bmp[r][15 - c];
    endfunction

    always @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            m_ax = 0; m_ay = 0; m_px = 0; m_py = 0;
            m_pv = 1'b0; m_af = 1'b0; m_pf = 1'b0;
            for (int i = 0; i < 16; i++) m_bmp[i] = 16'h0000;
            m_ve_d = 1'b0; m_spr_d = 1'b0; m_color = 12'h000;
        end else begin
            // Colours are live: the output uses colours present one edge after the coordinate.
            m_color = m_ve_d ? (m_spr_d ? bus.sprite_color : bus.bg_color) : 12'h000;
            m_ve_d  = bus.video_enable;
            m_spr_d = sprite_px(int'(bus.h_pos), int'(bus.v_pos));
            if (bus.bmp_we) m_bmp[bus.bmp_row] = bus.bmp_data;
            if (bus.frame_tick && m_pv) begin
                m_ax = m_px; m_ay = m_py; m_af = m_pf; m_pv = 1'b0;
            end
            if (bus.pos_we) begin
                m_px = int'(bus.pos_x); m_py = int'(bus.pos_y); m_pv = 1'b1;
`ifdef SPRITE_FLIP_EN
                m_pf = bus.flip_h;
`endif
            end
        end
    end

    always @(negedge pixel_clk) begin
        if (chk_en) begin
            checks++;
            if (bus.color_data !== m_color) begin
                errors++;
                $display("FAIL model_color t=%0t got %h exp %h", $time, bus.color_data, m_color);
            end
            checks++;
            if (bus.pos_pending !== m_pv) begin
                errors++;
                $display("FAIL model_pending t=%0t got %b exp %b", $time, bus.pos_pending, m_pv);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(string name, logic [11:0] got, logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge pixel_clk);
        bus.pos_we     = 1'b0;
        bus.bmp_we     = 1'b0;
        bus.frame_tick = 1'b0;
    endtask

    task automatic coord_ve(int h, int v, bit ve);
        cyc();
        bus.h_pos        = 10'(h);
        bus.v_pos        = 10'(v);
        bus.video_enable = ve;
    endtask

    task automatic coord(int h, int v);
        coord_ve(h, v, (h < c_h_max) && (v < c_v_max));
    endtask

    task automatic expect_px(string name, int h, int v, bit ve, logic [11:0] exp);
        coord_ve(h, v, ve);
        cyc();
        cyc();
        check(name, bus.color_data, exp);
    endtask

    task automatic write_rows(logic [15:0] d);
        for (int r = 0; r < 16; r++) begin
            cyc();
            bus.bmp_we   = 1'b1;
            bus.bmp_row  = 4'(r);
            bus.bmp_data = d;
        end
    endtask

    task automatic write_pos(int x, int y);
        cyc();
        bus.pos_we = 1'b1;
        bus.pos_x  = 10'(x);
        bus.pos_y  = 10'(y);
    endtask

    task automatic commit();
        cyc();
        bus.frame_tick = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bus.h_pos = '0; bus.v_pos = '0; bus.video_enable = 1'b0;
        bus.frame_tick = 1'b0; bus.pos_we = 1'b0; bus.pos_x = '0; bus.pos_y = '0;
        bus.bmp_we = 1'b0; bus.bmp_row = '0; bus.bmp_data = '0;
        bus.sprite_color = 12'hF00; bus.bg_color = 12'h00F;
`ifdef SPRITE_FLIP_EN
        bus.flip_h = 1'b0;
`endif
        cyc();
        chk_en = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        check("reset_color", bus.color_data, 12'h000);
        check("reset_pending", {11'd0, bus.pos_pending}, 12'h000);

        // Subsampled full frame: bitmap empty, so only background or blank.
        for (int v = 0; v < 525; v++)
            for (int h = 0; h < 800; h += 16)
                coord(h, v);
        expect_px("frame_active", 320, 240, 1'b1, 12'h00F);
        expect_px("frame_blank",  700, 10,  1'b0, 12'h000);

        // Edge columns of the sprite, nothing shown before commit.
        write_rows(16'h8001);
        write_pos(100, 50);
        cyc();
        check("pending_set", {11'd0, bus.pos_pending}, 12'h001);
        expect_px("pre_commit", 100, 50, 1'b1, 12'h00F);
        commit();
        cyc();
        check("pending_clr", {11'd0, bus.pos_pending}, 12'h000);
        expect_px("left_col",   100, 50, 1'b1, 12'hF00);
        expect_px("right_col",  115, 50, 1'b1, 12'hF00);
        expect_px("inner_col",  101, 50, 1'b1, 12'h00F);
        expect_px("past_right", 116, 50, 1'b1, 12'h00F);

        // Write colliding with commit: old pending goes live, new stays pending.
        write_pos(10, 10);
        cyc();
        bus.pos_we = 1'b1; bus.pos_x = 10'd200; bus.pos_y = 10'd200;
        bus.frame_tick = 1'b1;
        cyc();
        check("collide_pending", {11'd0, bus.pos_pending}, 12'h001);
        expect_px("collide_old", 10, 10, 1'b1, 12'hF00);
        expect_px("collide_new_hidden", 200, 200, 1'b1, 12'h00F);
        commit();
        cyc();
        check("collide_commit_pending", {11'd0, bus.pos_pending}, 12'h000);
        expect_px("collide_new", 200, 200, 1'b1, 12'hF00);
        expect_px("collide_old_gone", 10, 10, 1'b1, 12'h00F);

        // Bottom-right clipping against the active area.
        write_rows(16'hFFFF);
        write_pos(630, 470);
        commit();
        for (int v = 466; v < 485; v++)
            for (int h = 626; h < 645; h++)
                coord(h, v);
        expect_px("clip_corner",   639, 479, 1'b1, 12'hF00);
        expect_px("clip_origin",   630, 470, 1'b1, 12'hF00);
        expect_px("clip_left",     629, 470, 1'b1, 12'h00F);
        expect_px("clip_hmax",     640, 479, 1'b1, 12'h00F);
        expect_px("clip_vmax",     639, 480, 1'b1, 12'h00F);
        expect_px("clip_blank",    640, 470, 1'b0, 12'h000);

        // Sprite end computed without 10-bit wrap.
        write_pos(1020, 0);
        commit();
        expect_px("no_wrap", 3, 0, 1'b1, 12'h00F);

        // Two-cycle latency, then mid-line asynchronous reset.
        write_rows(16'h8001);
        write_pos(100, 50);
        commit();
        coord(300, 300);
        cyc(); cyc();
        coord(100, 50);
        cyc();
        check("latency_n1", bus.color_data, 12'h00F);
        cyc();
        check("latency_n2", bus.color_data, 12'hF00);
        @(posedge pixel_clk);
        #1 reset = 1'b1;
        #1;
        check("async_reset_color", bus.color_data, 12'h000);
        check("async_reset_pending", {11'd0, bus.pos_pending}, 12'h000);
        cyc(); cyc();
        reset = 1'b0;
        expect_px("post_reset_bg", 100, 50, 1'b1, 12'h00F);

`ifdef SPRITE_FLIP_EN
        cyc();
        bus.bmp_we = 1'b1; bus.bmp_row = 4'd0; bus.bmp_data = 16'h8000;
        bus.flip_h = 1'b1;
        write_pos(0, 0);
        commit();
        bus.flip_h = 1'b0;
        expect_px("flip_right", 15, 0, 1'b1, 12'hF00);
        expect_px("flip_left",  0,  0, 1'b1, 12'h00F);
`endif

        cyc();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sprite_layer.md
# sprite_layer

Single-sprite pixel generator that feeds the `color_data` input of the VGA output stage. It takes the current pixel coordinate from the timing generator and returns a 12-bit RGB colour two clocks later. The colour is either a 16×16 1-bpp sprite in a programmable colour or a background colour. Sprite position is double-buffered and commits only at frame boundaries, so it cannot tear.

## Interface
Parameters:
- `H_MAX`, default 640: active width; `h_pos` at or above this is never a sprite hit.
- `V_MAX`, default 480: active height; `v_pos` at or above this is never a sprite hit.

Ports:
- `pixel_clk`  in  1  pixel clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `h_pos`  in  10  current pixel column from the timing generator.
- `v_pos`  in  10  current pixel row from the timing generator.
- `video_enable`  in  1  high when (`h_pos`, `v_pos`) is inside the active area.
- `frame_tick`  in  1  one-cycle pulse at the start of vertical blank; the commit point.
- `pos_we`  in  1  write strobe for the pending sprite position.
- `pos_x`  in  10  pending sprite left column.
- `pos_y`  in  10  pending sprite top row.
- `bmp_we`  in  1  bitmap row write strobe.
- `bmp_row`  in  4  bitmap row index (0 = top).
- `bmp_data`  in  16  row bits; bit 15 is the leftmost pixel.
- `sprite_color`  in  12  RGB444 colour of set sprite pixels.
- `bg_color`  in  12  RGB444 colour of everything else.
- `color_data`  out  12  registered pixel colour to the VGA output stage.
- `pos_pending`  out  1  high while a written position has not yet been committed.

## Operation
- Registers:
  - `pend_x`/`pend_y`: pending position.
  - `act_x`/`act_y`: active position.
  - `pend_valid`: drives `pos_pending`.
  - `bitmap[0:15]`: 16 × 16-bit rows.
- Position write: `pos_we` loads `pend_x`/`pend_y` and sets `pend_valid`. The last write before a commit wins.
- Commit: `frame_tick` with `pend_valid=1` copies pending into active and clears `pend_valid`. `frame_tick` with `pend_valid=0` does nothing.
- Same-cycle `pos_we` and `frame_tick`:
  - The commit uses the pending value held before that cycle.
  - The new write lands in pending, and `pend_valid` stays 1.
- Bitmap write: `bmp_we` writes `bitmap[bmp_row] <= bmp_data` immediately, with no buffering. Mid-frame writes may tear; this is accepted.
- Hit test, stage 1:
  - `dx = h_pos - act_x` and `dy = v_pos - act_y`, computed 11 bits wide.
  - `hit` = `h_pos >= act_x` and `h_pos < act_x + 16` and `v_pos >= act_y` and `v_pos < act_y + 16` and `h_pos < H_MAX` and `v_pos < V_MAX`.
  - `act_x + 16` is computed in 11 bits, so there is no wrap. A sprite at `act_x = 1020` covers only columns 1020–1023, and right/bottom overflow is clipped.
  - Stage 1 registers `hit`, `dx[3:0]`, `bitmap[dy[3:0]]` and `video_enable`.
- Colour select, stage 2:
  - `bit = row[15 - col]`.
  - `color_data` = 0 if delayed `video_enable` = 0.
  - Otherwise `color_data` = `sprite_color` if `hit & bit`, else `bg_color`.
- `sprite_color` and `bg_color` are sampled live in stage 2; they are not buffered.

## Timing
- Reset values:
  - `color_data` = 12'h000, `pos_pending` = 0.
  - `act_x`, `act_y`, `pend_x`, `pend_y` = 0.
  - All bitmap rows = 0, so no sprite pixel is visible after reset.
  - Pipeline valid/hit flops = 0.
- Latency: `h_pos`/`v_pos`/`video_enable` at edge N produce `color_data` at edge N+2.
  - The timing generator drives coordinates 2 cycles ahead of its sync outputs.
  - The VGA output stage adds one more register.
- `pos_pending` rises the cycle after `pos_we` and falls the cycle after the committing `frame_tick`.
- A commit is visible from the first coordinate presented the cycle after `frame_tick`.
- A bitmap write at edge N affects coordinates sampled at edge N+1 and later.
- Reset asserted mid-frame: all state clears asynchronously, and `color_data` = 0 until 2 cycles after reset deassertion with `video_enable` high.

## Configuration
- `SPRITE_FLIP_EN` defined:
  - Adds input `flip_h` (1 bit). It is captured into a pending register on `pos_we` and committed with the position on `frame_tick`.
  - When the active flip is 1, stage 2 uses `bit = row[col]`, mirroring the sprite horizontally.
  - Reset value of the active flip is 0.
- `SPRITE_FLIP_EN` undefined: the `flip_h` port is absent and `bit = row[15 - col]` always.

## Test plan
- Reset, then sweep one full frame with `bg_color`=12'h00F → every active pixel = 12'h00F, every blank pixel = 12'h000, `pos_pending`=0.
- Load all rows = 16'h8001 with `sprite_color`=12'hF00, `pos_we` (100,50), then `frame_tick` → F00 at (100,50) and (115,50), 00F at (101,50) and (116,50); nothing drawn before the commit.
- `pos_we` (200,200) in the same cycle as `frame_tick`, after (10,10) was pending → active = (10,10), `pos_pending` stays 1; the next `frame_tick` moves the sprite to (200,200).
- Position (630,470), H_MAX=640, V_MAX=480, all rows = 16'hFFFF → F00 for columns 630–639 and rows 470–479 only; 000 outside the active area.
- Drive coordinate (100,50) at edge N → `color_data` = F00 at N+2; assert `reset` mid-line → `color_data` = 000 immediately.
- With `SPRITE_FLIP_EN`: row 0 = 16'h8000, `flip_h`=1, position (0,0) → F00 at (15,0) and 00F at (0,0).
